seg_digit_counter: RTL and testbench

- Upstream producer for the 7-bit enabled display register: a prescaled, modulo-(MAX_DIGIT+1) up/down decimal digit counter.
- Encodes the current digit into a 7-segment pattern.
- Issues a one-cycle seg_valid strobe that drives the downstream register's enable, so that register loads only when the pattern changes.
- carry chains digits for multi-digit displays.

---
 rtl/seg_digit_counter.sv | 119 +++++++++++
 tb/tb_seg_digit_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_counter.sv
// rtl/seg_digit_counter.sv - prescaled up/down decimal digit counter with 7-segment output and load strobe
module seg_digit_counter #(
  parameter int unsigned PRESCALE       = 4,
  parameter int unsigned MAX_DIGIT      = 9,
  parameter bit          ACTIVE_LOW_SEG = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       up,
  input  logic       clear,
  output logic [3:0] digit,
  output logic [6:0] seg,
  output logic       seg_valid,
  output logic       carry
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [3:0]  DIG_MAX  = 4'(MAX_DIGIT);
  localparam logic [6:0]  SEG_ZERO = ACTIVE_LOW_SEG ? 7'h40 : 7'h3F;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [3:0]  digit_q, digit_d;
  logic [6:0]  seg_q, seg_d;
  logic        seg_valid_q, seg_valid_d;
  logic        carry_q, carry_d;

  // Pattern bits are {g,f,e,d,c,b,a}; common-anode builds invert every bit.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return ACTIVE_LOW_SEG ? ~p : p;
  endfunction

  // Next-state: INIT announces digit 0 once; COUNT handles clear, prescaler and digit steps.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    digit_d     = digit_q;
    seg_valid_d = 1'b0;
    carry_d     = 1'b0;
    if (state_q == ST_INIT) begin
      state_d     = ST_COUNT;
      pre_d       = '0;
      digit_d     = '0;
      seg_valid_d = 1'b1;
    end else if (clear) begin
      pre_d       = '0;
      digit_d     = '0;
      seg_valid_d = 1'b1;
    end else if (run) begin
      if (pre_q == PRE_LAST) begin
        pre_d       = '0;
        seg_valid_d = 1'b1;
        if (up) begin
          if (digit_q == DIG_MAX) begin
            digit_d = '0;
            carry_d = 1'b1;
          end else begin
            digit_d = digit_q + 4'd1;
          end
        end else begin
          if (digit_q == 4'd0) begin
            digit_d = DIG_MAX;
            carry_d = 1'b1;
          end else begin
            digit_d = digit_q - 4'd1;
          end
        end
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
    seg_d = encode(digit_d);
  end

  // State and output registers; reset drops any strobe in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      pre_q       <= '0;
      digit_q     <= '0;
      seg_q       <= SEG_ZERO;
      seg_valid_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      digit_q     <= digit_d;
      seg_q       <= seg_d;
      seg_valid_q <= seg_valid_d;
      carry_q     <= carry_d;
    end
  end

  assign digit     = digit_q;
  assign seg       = seg_q;
  assign seg_valid = seg_valid_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_seg_digit_counter.sv
// tb/tb_seg_digit_counter.sv - scoreboard bench for seg_digit_counter
module tb_seg_digit_counter;

  typedef struct packed {
    int         cyc;
    logic [3:0] d;
    logic [6:0] s;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       reset0, run0, up0, clear0;
  logic [3:0] digit0;
  logic [6:0] seg0;
  logic       seg_valid0, carry0;

  logic       reset1, run1, up1, clear1;
  logic [3:0] digit1;
  logic [6:0] seg1;
  logic       seg_valid1, carry1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n0 = 0;
  int   n1 = 0;
  int   t, s;

  seg_digit_counter #(.PRESCALE(4), .MAX_DIGIT(9), .ACTIVE_LOW_SEG(1'b0)) u0 (
    .clk(clk), .reset(reset0), .run(run0), .up(up0), .clear(clear0),
    .digit(digit0), .seg(seg0), .seg_valid(seg_valid0), .carry(carry0)
  );

  seg_digit_counter #(.PRESCALE(1), .MAX_DIGIT(5), .ACTIVE_LOW_SEG(1'b1)) u1 (
    .clk(clk), .reset(reset1), .run(run1), .up(up1), .clear(clear1),
    .digit(digit1), .seg(seg1), .seg_valid(seg_valid1), .carry(carry1)
  );

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push0(input int c, input int d, input logic [6:0] sg, input logic cr);
    exp_t e;
    e.cyc = c; e.d = 4'(d); e.s = sg; e.c = cr;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input int d, input logic [6:0] sg, input logic cr);
    exp_t e;
    e.cyc = c; e.d = 4'(d); e.s = sg; e.c = cr;
    q1.push_back(e);
  endtask

  // Monitor for u0: every strobe must match the next expected entry, including its cycle.
  always @(negedge clk) begin
    if (seg_valid0) begin
      if (q0.size() == 0) begin
        chk($sformatf("u0 unexpected_strobe cyc=%0d digit=%0d", cyc, digit0), seg_valid0, 0);
      end else begin
        e0 = q0.pop_front();
        n0++;
        chk($sformatf("u0 strobe%0d cycle", n0), cyc, e0.cyc);
        chk($sformatf("u0 strobe%0d digit", n0), digit0, e0.d);
        chk($sformatf("u0 strobe%0d seg", n0), seg0, e0.s);
        chk($sformatf("u0 strobe%0d carry", n0), carry0, e0.c);
      end
    end else if (carry0) begin
      chk($sformatf("u0 carry_without_valid cyc=%0d", cyc), carry0, 0);
    end
  end

  // Monitor for u1.
  always @(negedge clk) begin
    if (seg_valid1) begin
      if (q1.size() == 0) begin
        chk($sformatf("u1 unexpected_strobe cyc=%0d digit=%0d", cyc, digit1), seg_valid1, 0);
      end else begin
        e1 = q1.pop_front();
        n1++;
        chk($sformatf("u1 strobe%0d cycle", n1), cyc, e1.cyc);
        chk($sformatf("u1 strobe%0d digit", n1), digit1, e1.d);
        chk($sformatf("u1 strobe%0d seg", n1), seg1, e1.s);
        chk($sformatf("u1 strobe%0d carry", n1), carry1, e1.c);
      end
    end else if (carry1) begin
      chk($sformatf("u1 carry_without_valid cyc=%0d", cyc), carry1, 0);
    end
  end

  initial begin
    reset0 = 1'b0; run0 = 1'b0; up0 = 1'b1; clear0 = 1'b0;
    reset1 = 1'b0; run1 = 1'b1; up1 = 1'b1; clear1 = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("u0 reset digit", digit0, 0);
    chk("u0 reset seg", seg0, 7'h3F);
    chk("u0 reset seg_valid", seg_valid0, 0);
    chk("u0 reset carry", carry0, 0);

    // Release with run=1, up=1: INIT strobe, then a tick every 4th edge, wrap 9->0 with carry.
    reset0 = 1'b1; run0 = 1'b1; t = cyc;
    push0(t + 1, 0, code(0), 1'b0);
    for (int k = 1; k <= 10; k++) push0(t + 1 + 4 * k, k % 10, code(k % 10), k == 10);
    repeat (44) @(negedge clk);

    // Down count from 0: borrow to 9 with carry, then 8 without.
    up0 = 1'b0;
    push0(t + 45, 9, code(9), 1'b1);
    push0(t + 49, 8, code(8), 1'b0);
    repeat (5) @(negedge clk);

    // Pause with the prescaler at its last value; tick lands one edge after resume.
    repeat (3) @(negedge clk);
    run0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("u0 pause digit", digit0, 8);
    run0 = 1'b1;
    push0(t + 63, 7, code(7), 1'b0);
    push0(t + 67, 6, code(6), 1'b0);
    push0(t + 71, 5, code(5), 1'b0);
    push0(t + 75, 0, code(0), 1'b0);
    repeat (12) @(negedge clk);

    // Clear coincident with a tick at digit 5; next tick four edges later counting up.
    clear0 = 1'b1; up0 = 1'b1;
    @(negedge clk);
    clear0 = 1'b0;
    for (int k = 1; k <= 7; k++) push0(t + 75 + 4 * k, k, code(k), 1'b0);
    repeat (28) @(negedge clk);

    // Async reset between edges while the digit-7 strobe is visible.
    #2 reset0 = 1'b0;
    #1;
    chk("u0 async digit", digit0, 0);
    chk("u0 async seg", seg0, 7'h3F);
    chk("u0 async seg_valid", seg_valid0, 0);
    chk("u0 async carry", carry0, 0);
    repeat (3) @(negedge clk);

    // u1: PRESCALE=1, MAX_DIGIT=5, inverted segments; strobe every cycle, wrap 5->0.
    chk("u1 reset seg", seg1, 7'h40);
    chk("u1 reset seg_valid", seg_valid1, 0);
    reset1 = 1'b1; s = cyc;
    push1(s + 1, 0, code(0) ^ 7'h7F, 1'b0);
    for (int k = 1; k <= 5; k++) push1(s + 1 + k, k, code(k) ^ 7'h7F, 1'b0);
    push1(s + 7, 0, code(0) ^ 7'h7F, 1'b1);
    repeat (7) @(negedge clk);
    run1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("u1 hold digit", digit1, 0);
    chk("u1 hold seg", seg1, 7'h40);

    chk("u0 missing_strobes", q0.size(), 0);
    chk("u1 missing_strobes", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
